// File: rtl/clk_div_prog_if.sv
// rtl/clk_div_prog_if.sv - control/status bundle for the programmable clock divider
interface clk_div_prog_if #(
   parameter int CNT_W = 16
);
   logic             en;
   logic [CNT_W-1:0] div_in;
   logic             div_load;
   logic             sync;
   logic             clk_out;
   logic             tick;
   logic             running;
   logic             busy;
   logic             div_err;
   logic [CNT_W-1:0] div_cur;

   modport master (
      output en, div_in, div_load, sync,
      input  clk_out, tick, running, busy, div_err, div_cur
   );

   modport slave (
      input  en, div_in, div_load, sync,
      output clk_out, tick, running, busy, div_err, div_cur
   );
endinterface

// File: rtl/clk_div_prog.sv
// rtl/clk_div_prog.sv - runtime-programmable integer clock divider
module clk_div_prog #(
   parameter int CNT_W       = 16,
   parameter int DEFAULT_DIV = 2
) (
   input  logic          clk_in,
   input  logic          reset,
   clk_div_prog_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);
   localparam logic [CNT_W-1:0] MIN_DIV = CNT_W'(2);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] pend;
   logic [CNT_W-1:0] div_cur;
   logic [CNT_W-1:0] high;
   logic [CNT_W-1:0] last;
   logic             clk_out;
   logic             tick;
   logic             busy;
   logic             div_err;
   logic             load_ok;
   logic             at_end;
   logic             boundary;

   always_comb begin
      high     = div_cur >> 1;
      last     = div_cur - CNT_W'(1);
      at_end   = (cnt == last);
      load_ok  = bus.div_load && (bus.div_in >= MIN_DIV);
      boundary = (state == IDLE) || bus.sync || at_end;
   end

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= '0;
         clk_out <= 1'b0;
         tick    <= 1'b0;
         busy    <= 1'b0;
         div_err <= 1'b0;
         div_cur <= DEF_DIV;
         pend    <= DEF_DIV;
      end else begin
         div_err <= bus.div_load && (bus.div_in < MIN_DIV);

         if (state == IDLE) begin
            cnt     <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
            if (bus.en)
               state <= RUN;
         end else if (bus.sync || at_end) begin
            // End of a period (natural or forced): en decides whether another one starts
            cnt     <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
            state   <= bus.en ? RUN : IDLE;
         end else begin
            cnt     <= cnt + CNT_W'(1);
            clk_out <= (cnt < high);
            tick    <= (state == RUN) && (cnt == '0);
            state   <= bus.en ? RUN : DRAIN;
         end

         // A load in IDLE takes effect at once; otherwise it waits for the next boundary
         if ((state == IDLE) && load_ok) begin
            div_cur <= bus.div_in;
            busy    <= 1'b0;
         end else begin
            if (boundary && busy) begin
               div_cur <= pend;
               busy    <= 1'b0;
            end
            if (load_ok) begin
               pend <= bus.div_in;
               busy <= 1'b1;
            end
         end
      end
   end

   assign bus.clk_out = clk_out;
   assign bus.tick    = tick;
   assign bus.running = (state != IDLE);
   assign bus.busy    = busy;
   assign bus.div_err = div_err;
   assign bus.div_cur = div_cur;
endmodule

// File: tb/tb_clk_div_prog.sv
// tb/tb_clk_div_prog.sv - self-checking bench for clk_div_prog
module tb_clk_div_prog;
   localparam int CNT_W   = 16;
   localparam int DEF_DIV = 2;

   logic clk_in = 1'b0;
   logic reset;

   clk_div_prog_if #(.CNT_W(CNT_W)) dif ();

   clk_div_prog #(.CNT_W(CNT_W), .DEFAULT_DIV(DEF_DIV)) dut (
      .clk_in (clk_in),
      .reset  (reset),
      .bus    (dif)
   );

   always #5 clk_in = ~clk_in;

   int checks   = 0;
   int failures = 0;

   // Reference model: each period is a queue of output samples built when it starts
   bit               m_run;
   bit               wave[$];
   logic [CNT_W-1:0] e_div;
   logic [CNT_W-1:0] m_pend;
   bit               e_clk, e_tick, e_busy, e_err;

   function automatic logic [20:0] act_vec();
      return {dif.clk_out, dif.tick, dif.running, dif.busy, dif.div_err, dif.div_cur};
   endfunction

   function automatic logic [20:0] exp_vec();
      return {e_clk, e_tick, m_run, e_busy, e_err, e_div};
   endfunction

   task automatic model_reset();
      m_run  = 0;
      wave.delete();
      e_div  = CNT_W'(DEF_DIV);
      m_pend = CNT_W'(DEF_DIV);
      e_clk  = 0;
      e_tick = 0;
      e_busy = 0;
      e_err  = 0;
   endtask

   task automatic model_edge();
      bit was_idle = !m_run;
      bit ld_ok    = dif.div_load && (dif.div_in >= 16'd2);
      bit bnd      = 0;
      e_clk  = 0;
      e_tick = 0;
      if (!m_run) begin
         bnd   = 1;
         m_run = dif.en;
         wave.delete();
      end else if (dif.sync) begin
         bnd   = 1;
         m_run = dif.en;
         wave.delete();
      end else begin
         if (wave.size() == 0) begin
            for (int i = 0; i < int'(e_div); i++)
               wave.push_back(i < int'(e_div) / 2);
            e_tick = 1;
         end
         e_clk = wave.pop_front();
         if (wave.size() == 0) begin
            bnd   = 1;
            m_run = dif.en;
         end
      end
      if (bnd && e_busy) begin
         e_div  = m_pend;
         e_busy = 0;
      end
      if (ld_ok) begin
         if (was_idle) begin
            e_div  = dif.div_in;
            e_busy = 0;
         end else begin
            m_pend = dif.div_in;
            e_busy = 1;
         end
      end
      e_err = dif.div_load && (dif.div_in < 16'd2);
   endtask

   task automatic step();
      @(posedge clk_in);
      model_edge();
      #1;
      dif.div_load = 0;
      dif.sync     = 0;
   endtask

   task automatic do_reset();
      dif.en       = 0;
      dif.div_load = 0;
      dif.sync     = 0;
      dif.div_in   = '0;
      reset        = 1;
      model_reset();
      @(posedge clk_in);
      #1;
      reset = 0;
   endtask

   task automatic load_idle(input int d);
      dif.div_in   = CNT_W'(d);
      dif.div_load = 1;
      step();
   endtask

   task automatic test_reset();
      dif.en       = 0;
      dif.div_load = 0;
      dif.sync     = 0;
      dif.div_in   = '0;
      reset        = 1;
      model_reset();
      #2;
      checks++;
      if (act_vec() !== {5'b00000, 16'(DEF_DIV)}) begin
         failures++;
         $display("FAIL reset_state dut=%h want=%h", act_vec(), {5'b00000, 16'(DEF_DIV)});
      end
      @(posedge clk_in);
      #1;
      reset = 0;
   endtask

   task automatic test_div2();
      logic [5:0] pat;
      do_reset();
      dif.en = 1;
      for (int i = 1; i <= 12; i++) begin
         step();
         if (i <= 6) pat[6-i] = dif.clk_out;
         checks++;
         if (act_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL div2 cyc=%0d dut=%h model=%h", i, act_vec(), exp_vec());
         end
      end
      checks++;
      if (pat !== 6'b010101) begin
         failures++;
         $display("FAIL div2_pattern dut=%b want=010101", pat);
      end
   endtask

   task automatic test_load_idle();
      int ticks = 0, highs = 0;
      bit busy_seen = 0;
      do_reset();
      load_idle(5);
      checks++;
      if (dif.div_cur !== 16'd5 || dif.busy !== 1'b0) begin
         failures++;
         $display("FAIL load_idle_direct div_cur=%0d busy=%b want 5/0", dif.div_cur, dif.busy);
      end
      dif.en = 1;
      for (int i = 1; i <= 20; i++) begin
         step();
         ticks += int'(dif.tick);
         highs += int'(dif.clk_out);
         busy_seen |= dif.busy;
         checks++;
         if (act_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL load_idle cyc=%0d dut=%h model=%h", i, act_vec(), exp_vec());
         end
      end
      checks++;
      if (ticks != 4 || highs != 8 || busy_seen) begin
         failures++;
         $display("FAIL div5_shape ticks=%0d highs=%0d busy=%b want 4/8/0", ticks, highs, busy_seen);
      end
   endtask

   task automatic test_back_to_back();
      int tk[$];
      do_reset();
      load_idle(8);
      dif.en = 1;
      for (int i = 1; i <= 24; i++) begin
         if (i == 4) begin dif.div_in = 16'd5; dif.div_load = 1; end
         if (i == 5) begin dif.div_in = 16'd3; dif.div_load = 1; end
         step();
         if (dif.tick) tk.push_back(i);
         checks++;
         if (act_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL reload cyc=%0d dut=%h model=%h", i, act_vec(), exp_vec());
         end
      end
      checks++;
      if (tk.size() < 3 || tk[1] - tk[0] != 8 || tk[2] - tk[1] != 3 || dif.div_cur !== 16'd3) begin
         failures++;
         $display("FAIL reload_periods nticks=%0d div_cur=%0d want periods 8 then 3", tk.size(), dif.div_cur);
      end
   endtask

   task automatic test_div_err();
      do_reset();
      load_idle(4);
      dif.en = 1;
      for (int i = 1; i <= 16; i++) begin
         if (i == 5) begin dif.div_in = 16'd1; dif.div_load = 1; end
         if (i == 9) begin dif.div_in = 16'd0; dif.div_load = 1; end
         step();
         checks++;
         if (act_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL div_err cyc=%0d dut=%h model=%h", i, act_vec(), exp_vec());
         end
         if (i == 5 || i == 9) begin
            checks++;
            if (dif.div_err !== 1'b1 || dif.busy !== 1'b0 || dif.div_cur !== 16'd4) begin
               failures++;
               $display("FAIL div_err_pulse cyc=%0d err=%b busy=%b div_cur=%0d want 1/0/4",
                        i, dif.div_err, dif.busy, dif.div_cur);
            end
         end
      end
   endtask

   task automatic test_drain();
      int last_run = 0, ticks = 0;
      int tk[$];
      bit dropped = 0;
      do_reset();
      load_idle(6);
      dif.en = 1;
      for (int i = 1; i <= 14; i++) begin
         if (i == 3) dif.en = 0;
         step();
         if (dif.running) last_run = i;
         ticks += int'(dif.tick);
         checks++;
         if (act_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL drain cyc=%0d dut=%h model=%h", i, act_vec(), exp_vec());
         end
      end
      checks++;
      if (last_run != 6 || ticks != 1 || dif.clk_out !== 1'b0) begin
         failures++;
         $display("FAIL drain_stop last_run=%0d ticks=%0d clk=%b want 6/1/0", last_run, ticks, dif.clk_out);
      end
      do_reset();
      load_idle(6);
      dif.en = 1;
      for (int i = 1; i <= 20; i++) begin
         if (i == 3) dif.en = 0;
         if (i == 6) dif.en = 1;
         step();
         if (!dif.running) dropped = 1;
         if (dif.tick) tk.push_back(i);
         checks++;
         if (act_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL drain_resume cyc=%0d dut=%h model=%h", i, act_vec(), exp_vec());
         end
      end
      checks++;
      if (dropped || tk.size() < 2 || tk[1] - tk[0] != 6) begin
         failures++;
         $display("FAIL drain_resume_gap dropped=%b nticks=%0d want no gap, period 6", dropped, tk.size());
      end
   endtask

   task automatic test_reset_sync();
      do_reset();
      load_idle(7);
      dif.en = 1;
      for (int i = 1; i <= 3; i++) begin
         if (i == 3) begin dif.div_in = 16'd4; dif.div_load = 1; end
         step();
      end
      checks++;
      if (dif.clk_out !== 1'b1 || dif.busy !== 1'b1) begin
         failures++;
         $display("FAIL pre_reset_high clk=%b busy=%b want 1/1", dif.clk_out, dif.busy);
      end
      #2;
      reset = 1;
      model_reset();
      #1;
      checks++;
      if (act_vec() !== {5'b00000, 16'(DEF_DIV)}) begin
         failures++;
         $display("FAIL mid_reset dut=%h want=%h", act_vec(), {5'b00000, 16'(DEF_DIV)});
      end
      dif.en = 0;
      @(posedge clk_in);
      #1;
      reset = 0;
      load_idle(7);
      dif.en = 1;
      for (int i = 1; i <= 12; i++) begin
         if (i == 5) dif.sync = 1;
         step();
         checks++;
         if (act_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL sync cyc=%0d dut=%h model=%h", i, act_vec(), exp_vec());
         end
         if (i == 5 || i == 6) begin
            checks++;
            if ({dif.clk_out, dif.tick} !== ((i == 6) ? 2'b11 : 2'b00)) begin
               failures++;
               $display("FAIL sync_phase cyc=%0d clk/tick=%b%b", i, dif.clk_out, dif.tick);
            end
         end
      end
   endtask

   task automatic test_random();
      do_reset();
      dif.en = 1;
      for (int i = 1; i <= 1500; i++) begin
         if ($urandom_range(0, 29) == 0) dif.en = ~dif.en;
         if ($urandom_range(0, 7) == 0) begin
            dif.div_in   = CNT_W'($urandom_range(0, 12));
            dif.div_load = 1;
         end
         if ($urandom_range(0, 39) == 0) dif.sync = 1;
         step();
         checks++;
         if (act_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL random cyc=%0d dut=%h model=%h", i, act_vec(), exp_vec());
         end
      end
   endtask

   initial begin
      test_reset();
      test_div2();
      test_load_idle();
      test_back_to_back();
      test_div_err();
      test_drain();
      test_reset_sync();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
